// File: rtl/noc_link_pkg.sv
// Shared flit type and sizing helper for the NoC pipeline link.
// Latency: n/a (types only); backpressure: n/a.
package noc_link_pkg;

  localparam int LINK_FLIT_WIDTH = 32;
  localparam int LINK_DEST_WIDTH = 6;

  typedef struct packed {
    logic [LINK_FLIT_WIDTH-1:0] data;
    logic [LINK_DEST_WIDTH-1:0] dest;
    logic                       is_tail;
  } flit_t;

  function automatic int credit_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_link_monitor.sv
// Upstream-side observer: credit counter, wormhole dest check, sticky errors, stats.
// Latency: flags/counters update one cycle after the event; never stalls the link.
module noc_link_monitor
  import noc_link_pkg::*;
#(
  parameter int DEST_WIDTH        = LINK_DEST_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CNT_WIDTH         = 32,
  localparam int CRD_W            = credit_cnt_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send_in,
  input  logic                  is_tail_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  credit_in,
  input  logic                  err_clear,
  output logic [CRD_W-1:0]      credits_avail,
  output logic                  err_overrun,
  output logic                  err_credit,
  output logic                  err_dest,
  output logic [CNT_WIDTH-1:0]  flit_count,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(FLIT_BUFFER_DEPTH);

  logic [CRD_W-1:0]      credits_q, credits_d;
  logic                  open_q, open_d;
  logic [DEST_WIDTH-1:0] pkt_dest_q, pkt_dest_d;
  logic                  err_overrun_q, err_overrun_d;
  logic                  err_credit_q, err_credit_d;
  logic                  err_dest_q, err_dest_d;
  logic [CNT_WIDTH-1:0]  flit_count_q, flit_count_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
  logic                  ev_overrun, ev_credit, ev_dest;

  // Simultaneous send and credit cancel out, so only the one-sided cases can hit a bound.
  always_comb begin
    credits_d  = credits_q;
    ev_overrun = 1'b0;
    ev_credit  = 1'b0;
    if (send_in && !credit_in) begin
      if (credits_q == '0) ev_overrun = 1'b1;
      else                 credits_d  = credits_q - 1'b1;
    end else if (!send_in && credit_in) begin
      if (credits_q == CRD_MAX) ev_credit = 1'b1;
      else                      credits_d = credits_q + 1'b1;
    end
  end

  always_comb begin
    open_d     = open_q;
    pkt_dest_d = pkt_dest_q;
    ev_dest    = 1'b0;
    if (send_in) begin
      if (!open_q) begin
        if (!is_tail_in) begin
          open_d     = 1'b1;
          pkt_dest_d = dest_in;
        end
      end else begin
        ev_dest = (dest_in != pkt_dest_q);
        if (is_tail_in) open_d = 1'b0;
      end
    end
  end

  always_comb begin
    err_overrun_d = (err_overrun_q & ~err_clear) | ev_overrun;
    err_credit_d  = (err_credit_q  & ~err_clear) | ev_credit;
    err_dest_d    = (err_dest_q    & ~err_clear) | ev_dest;
    flit_count_d  = flit_count_q + CNT_WIDTH'(send_in);
    pkt_count_d   = pkt_count_q  + CNT_WIDTH'(send_in & is_tail_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q     <= CRD_MAX;
      open_q        <= 1'b0;
      pkt_dest_q    <= '0;
      err_overrun_q <= 1'b0;
      err_credit_q  <= 1'b0;
      err_dest_q    <= 1'b0;
      flit_count_q  <= '0;
      pkt_count_q   <= '0;
    end else begin
      credits_q     <= credits_d;
      open_q        <= open_d;
      pkt_dest_q    <= pkt_dest_d;
      err_overrun_q <= err_overrun_d;
      err_credit_q  <= err_credit_d;
      err_dest_q    <= err_dest_d;
      flit_count_q  <= flit_count_d;
      pkt_count_q   <= pkt_count_d;
    end
  end

  assign credits_avail = credits_q;
  assign err_overrun   = err_overrun_q;
  assign err_credit    = err_credit_q;
  assign err_dest      = err_dest_q;
  assign flit_count    = flit_count_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: rtl/noc_pipeline_link.sv
// Credit-based flit retiming link with an observe-only upstream protocol monitor.
// Latency: NUM_PIPELINE cycles each way; no backpressure beyond the credit loop.
module noc_pipeline_link
  import noc_link_pkg::*;
#(
  parameter int NUM_PIPELINE      = 1,
  parameter int FLIT_WIDTH        = LINK_FLIT_WIDTH,
  parameter int DEST_WIDTH        = LINK_DEST_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [credit_cnt_width(FLIT_BUFFER_DEPTH)-1:0] credits_avail,
  input  logic                  err_clear,
  output logic                  err_overrun,
  output logic                  err_credit,
  output logic                  err_dest,
  output logic [CNT_WIDTH-1:0]  flit_count,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  // flit_t carries fixed field widths, so the width parameters must agree with it.
  if (FLIT_WIDTH != LINK_FLIT_WIDTH || DEST_WIDTH != LINK_DEST_WIDTH) begin : g_cfg_check
    $error("noc_pipeline_link: FLIT_WIDTH/DEST_WIDTH must match noc_link_pkg::flit_t");
  end

  flit_t flit_s   [NUM_PIPELINE+1];
  logic  send_s   [NUM_PIPELINE+1];
  logic  credit_s [NUM_PIPELINE+1];

  assign flit_s[0]   = '{data: data_in, dest: dest_in, is_tail: is_tail_in};
  assign send_s[0]   = send_in;
  assign credit_s[0] = credit_in;

  for (genvar k = 0; k < NUM_PIPELINE; k++) begin : g_fwd
    flit_t flit_q, flit_d;
    logic  send_q, send_d;

    // Payload is only captured under send, so idle cycles cost no toggles.
    always_comb begin
      send_d = send_s[k];
      flit_d = send_s[k] ? flit_s[k] : flit_q;
    end

    always_ff @(posedge clk) begin
      if (rst) send_q <= 1'b0;
      else     send_q <= send_d;
    end

    always_ff @(posedge clk) begin
      flit_q <= flit_d;
    end

    assign flit_s[k+1] = flit_q;
    assign send_s[k+1] = send_q;
  end

  for (genvar k = 0; k < NUM_PIPELINE; k++) begin : g_crd
    logic credit_q, credit_d;

    always_comb begin
      credit_d = credit_s[k];
    end

    always_ff @(posedge clk) begin
      if (rst) credit_q <= 1'b0;
      else     credit_q <= credit_d;
    end

    assign credit_s[k+1] = credit_q;
  end

  assign send_out   = send_s[NUM_PIPELINE];
  assign data_out   = flit_s[NUM_PIPELINE].data;
  assign dest_out   = flit_s[NUM_PIPELINE].dest;
  assign credit_out = credit_s[NUM_PIPELINE];

  // The unreset tail register is masked by send so it reads 0 out of reset.
  if (NUM_PIPELINE == 0) begin : g_tail_wire
    assign is_tail_out = flit_s[0].is_tail;
  end else begin : g_tail_gated
    assign is_tail_out = send_s[NUM_PIPELINE] & flit_s[NUM_PIPELINE].is_tail;
  end

  noc_link_monitor #(
    .DEST_WIDTH        (DEST_WIDTH),
    .FLIT_BUFFER_DEPTH (FLIT_BUFFER_DEPTH),
    .CNT_WIDTH         (CNT_WIDTH)
  ) u_monitor (
    .clk           (clk),
    .rst           (rst),
    .send_in       (send_in),
    .is_tail_in    (is_tail_in),
    .dest_in       (dest_in),
    .credit_in     (credit_out),
    .err_clear     (err_clear),
    .credits_avail (credits_avail),
    .err_overrun   (err_overrun),
    .err_credit    (err_credit),
    .err_dest      (err_dest),
    .flit_count    (flit_count),
    .pkt_count     (pkt_count)
  );

endmodule

// File: tb/tb_noc_pipeline_link.sv
// Three link instances (2, 3 and 0 stages) share one stimulus stream and are
// checked every cycle against a delay-history and counter model.
module tb_noc_pipeline_link;

  localparam int DEPTH = 4;
  localparam int HMAX  = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, send_in, is_tail_in, credit_in, err_clear;
  logic [31:0] data_in;
  logic [5:0]  dest_in;

  logic        o_send [3];
  logic        o_tail [3];
  logic        o_cred [3];
  logic        o_eov  [3];
  logic        o_ecr  [3];
  logic        o_eds  [3];
  logic [31:0] o_data [3];
  logic [5:0]  o_dest [3];
  logic [2:0]  o_avail[3];
  logic [31:0] o_flit [3];
  logic [31:0] o_pkt  [3];
  logic [3:0]  fc3, pc3;

  assign o_flit[1] = {28'd0, fc3};
  assign o_pkt[1]  = {28'd0, pc3};

  noc_pipeline_link #(.NUM_PIPELINE(2), .FLIT_BUFFER_DEPTH(DEPTH), .CNT_WIDTH(32)) u_p2 (
    .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in),
    .send_in(send_in), .credit_out(o_cred[0]), .data_out(o_data[0]), .dest_out(o_dest[0]),
    .is_tail_out(o_tail[0]), .send_out(o_send[0]), .credit_in(credit_in),
    .credits_avail(o_avail[0]), .err_clear(err_clear), .err_overrun(o_eov[0]),
    .err_credit(o_ecr[0]), .err_dest(o_eds[0]), .flit_count(o_flit[0]), .pkt_count(o_pkt[0]));

  noc_pipeline_link #(.NUM_PIPELINE(3), .FLIT_BUFFER_DEPTH(DEPTH), .CNT_WIDTH(4)) u_p3 (
    .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in),
    .send_in(send_in), .credit_out(o_cred[1]), .data_out(o_data[1]), .dest_out(o_dest[1]),
    .is_tail_out(o_tail[1]), .send_out(o_send[1]), .credit_in(credit_in),
    .credits_avail(o_avail[1]), .err_clear(err_clear), .err_overrun(o_eov[1]),
    .err_credit(o_ecr[1]), .err_dest(o_eds[1]), .flit_count(fc3), .pkt_count(pc3));

  noc_pipeline_link #(.NUM_PIPELINE(0), .FLIT_BUFFER_DEPTH(DEPTH), .CNT_WIDTH(32)) u_p0 (
    .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in),
    .send_in(send_in), .credit_out(o_cred[2]), .data_out(o_data[2]), .dest_out(o_dest[2]),
    .is_tail_out(o_tail[2]), .send_out(o_send[2]), .credit_in(credit_in),
    .credits_avail(o_avail[2]), .err_clear(err_clear), .err_overrun(o_eov[2]),
    .err_credit(o_ecr[2]), .err_dest(o_eds[2]), .flit_count(o_flit[2]), .pkt_count(o_pkt[2]));

  int checks;
  int failures;
  int cyc = 0;
  int last_rst = -1;
  bit chk_en = 1'b0;

  bit          h_send [HMAX];
  bit          h_tail [HMAX];
  bit          h_cred [HMAX];
  logic [31:0] h_data [HMAX];
  logic [5:0]  h_dest [HMAX];

  int          m_cnt  [3];
  bit          m_eov  [3];
  bit          m_ecr  [3];
  bit          m_eds  [3];
  bit          m_open [3];
  logic [5:0]  m_pdest[3];
  int unsigned m_flit [3];
  int unsigned m_pkt  [3];

  function automatic int np_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 0);
  endfunction

  function automatic logic [31:0] cnt_view(input int d, input int unsigned v);
    return (d == 1) ? (v % 16) : v;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk(nm, -1, act, exp);
  endtask

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    int  c, n, p;
    bit  ok, es, ec, et, eo, ek, ed;
    c = cyc;
    if (c < HMAX) begin
      h_send[c] = send_in;
      h_tail[c] = is_tail_in;
      h_cred[c] = credit_in;
      h_data[c] = data_in;
      h_dest[c] = dest_in;
      for (int d = 0; d < 3; d++) begin
        n  = np_of(d);
        p  = c - n;
        ok = (p >= 0) && (last_rst < p);
        es = 1'b0; ec = 1'b0; et = 1'b0;
        if (ok) begin
          es = h_send[p];
          ec = h_cred[p];
          et = h_tail[p];
        end
        if (chk_en) begin
          chk("send_out", d, 32'(o_send[d]), 32'(es));
          chk("credit_out", d, 32'(o_cred[d]), 32'(ec));
          if (es) begin
            chk("data_out", d, o_data[d], h_data[p]);
            chk("dest_out", d, 32'(o_dest[d]), 32'(h_dest[p]));
          end
          chk("is_tail_out", d, 32'(o_tail[d]), 32'((n == 0) ? et : (es & et)));
          chk("credits_avail", d, 32'(o_avail[d]), 32'(m_cnt[d]));
          chk("err_overrun", d, 32'(o_eov[d]), 32'(m_eov[d]));
          chk("err_credit", d, 32'(o_ecr[d]), 32'(m_ecr[d]));
          chk("err_dest", d, 32'(o_eds[d]), 32'(m_eds[d]));
          chk("flit_count", d, o_flit[d], cnt_view(d, m_flit[d]));
          chk("pkt_count", d, o_pkt[d], cnt_view(d, m_pkt[d]));
        end
        if (rst) begin
          m_cnt[d] = DEPTH; m_eov[d] = 0; m_ecr[d] = 0; m_eds[d] = 0;
          m_open[d] = 0; m_flit[d] = 0; m_pkt[d] = 0;
        end else begin
          eo = 0; ek = 0; ed = 0;
          if (send_in && !ec) begin
            if (m_cnt[d] == 0) eo = 1; else m_cnt[d] = m_cnt[d] - 1;
          end else if (!send_in && ec) begin
            if (m_cnt[d] == DEPTH) ek = 1; else m_cnt[d] = m_cnt[d] + 1;
          end
          if (send_in) begin
            m_flit[d] = m_flit[d] + 1;
            if (is_tail_in) m_pkt[d] = m_pkt[d] + 1;
            if (!m_open[d]) begin
              if (!is_tail_in) begin m_open[d] = 1; m_pdest[d] = dest_in; end
            end else begin
              if (dest_in != m_pdest[d]) ed = 1;
              if (is_tail_in) m_open[d] = 0;
            end
          end
          m_eov[d] = (m_eov[d] && !err_clear) || eo;
          m_ecr[d] = (m_ecr[d] && !err_clear) || ek;
          m_eds[d] = (m_eds[d] && !err_clear) || ed;
        end
      end
      if (rst) last_rst = c;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; send_in = 0; is_tail_in = 0; credit_in = 0; err_clear = 0;
    data_in = 32'h0; dest_in = 6'h0;
  endtask

  task automatic send_flit(input logic [31:0] dat, input logic [5:0] dst, input logic tl);
    send_in = 1; data_in = dat; dest_in = dst; is_tail_in = tl;
  endtask

  bit         s_open;
  logic [5:0] r_dest;

  initial begin
    checks = 0; failures = 0;
    idle(); rst = 1;
    repeat (3) tick();
    rst = 0; chk_en = 1;
    lit("rst_send_out", 32'(u_p2.send_out), 0);
    lit("rst_tail_out", 32'(u_p2.is_tail_out), 0);
    lit("rst_credit_out", 32'(u_p3.credit_out), 0);
    lit("rst_credits", 32'(u_p2.credits_avail), 4);
    lit("rst_flit_count", u_p2.flit_count, 0);

    // 3-flit packet through the 2-stage link
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        lit("pkt_send_c2", 32'(u_p2.send_out), 1);
        lit("pkt_data_c2", u_p2.data_out, 32'hA000_0000);
      end
      send_flit(32'hA000_0000 + 32'(i), 6'h15, (i == 2));
      tick();
    end
    idle();
    lit("pkt_send_c3", 32'(u_p2.send_out), 1);
    lit("pkt_data_c3", u_p2.data_out, 32'hA000_0001);
    lit("pkt_dest_c3", 32'(u_p2.dest_out), 32'h15);
    lit("pkt_tail_c3", 32'(u_p2.is_tail_out), 0);
    tick();
    lit("pkt_data_c4", u_p2.data_out, 32'hA000_0002);
    lit("pkt_tail_c4", 32'(u_p2.is_tail_out), 1);
    tick();
    lit("pkt_send_c5", 32'(u_p2.send_out), 0);
    lit("pkt_count_1", u_p2.pkt_count, 1);
    lit("flit_count_3", u_p2.flit_count, 3);
    lit("credits_1", 32'(u_p2.credits_avail), 1);

    // Exhaust credits, then overrun
    send_flit(32'h11, 6'h01, 1); tick(); idle();
    lit("credits_0", 32'(u_p2.credits_avail), 0);
    lit("no_overrun_at_0", 32'(u_p2.err_overrun), 0);
    send_flit(32'h12, 6'h01, 1); tick(); idle();
    lit("overrun_set", 32'(u_p2.err_overrun), 1);
    lit("credits_sat_0", 32'(u_p2.credits_avail), 0);

    // Back-to-back credits through 3 stages; same-cycle send+credit at NP=0
    err_clear = 1; tick(); idle();
    credit_in = 1; tick(); credit_in = 1; tick(); credit_in = 0;
    lit("p3_credit_t2", 32'(u_p3.credit_out), 0);
    tick();
    lit("p3_credit_t3", 32'(u_p3.credit_out), 1);
    tick();
    lit("p3_credit_t4", 32'(u_p3.credit_out), 1);
    tick();
    lit("p3_credit_t5", 32'(u_p3.credit_out), 0);
    lit("p0_credits_2", 32'(u_p0.credits_avail), 2);
    send_flit(32'h21, 6'h02, 1); credit_in = 1; tick(); idle();
    lit("p0_simul_keep_2", 32'(u_p0.credits_avail), 2);
    lit("p0_simul_no_err", 32'(u_p0.err_overrun), 0);
    repeat (3) tick();

    // Destination mismatch inside a packet and sticky-clear priority
    send_flit(32'h31, 6'h05, 0); tick();
    send_flit(32'h32, 6'h03, 0); tick(); idle();
    lit("dest_err_set", 32'(u_p2.err_dest), 1);
    err_clear = 1; tick(); idle();
    lit("dest_err_clr", 32'(u_p2.err_dest), 0);
    err_clear = 1; send_flit(32'h33, 6'h03, 0); tick(); idle();
    lit("dest_err_set_wins", 32'(u_p2.err_dest), 1);
    send_flit(32'h34, 6'h05, 1); tick(); idle();

    // Credit return beyond buffer depth
    err_clear = 1; tick(); idle();
    repeat (5) begin credit_in = 1; tick(); end
    idle();
    repeat (4) tick();
    lit("credits_full_4", 32'(u_p2.credits_avail), 4);
    lit("credit_err_set", 32'(u_p2.err_credit), 1);

    // Reset mid-packet with flits and credits in flight
    send_flit(32'h41, 6'h11, 0); credit_in = 1; tick();
    send_flit(32'h42, 6'h11, 0); tick();
    rst = 1; send_flit(32'h43, 6'h11, 0); tick(); idle();
    lit("mid_rst_send", 32'(u_p2.send_out), 0);
    lit("mid_rst_send_p3", 32'(u_p3.send_out), 0);
    lit("mid_rst_credit", 32'(u_p3.credit_out), 0);
    lit("mid_rst_credits", 32'(u_p2.credits_avail), 4);
    lit("mid_rst_flits", u_p2.flit_count, 0);
    lit("mid_rst_pkts", u_p2.pkt_count, 0);
    lit("mid_rst_ecr", 32'(u_p2.err_credit), 0);
    send_flit(32'h51, 6'h2A, 0); tick();
    send_flit(32'h52, 6'h2A, 0); tick();
    send_flit(32'h53, 6'h2A, 1); tick(); idle();
    lit("new_head_no_dest_err", 32'(u_p2.err_dest), 0);
    lit("new_pkt_count", u_p2.pkt_count, 1);
    lit("new_flit_count", u_p2.flit_count, 3);

    // Zero-stage link is a same-cycle wire
    send_flit(32'hDEAD_BEEF, 6'h3F, 1); credit_in = 1;
    #1;
    lit("p0_comb_send", 32'(u_p0.send_out), 1);
    lit("p0_comb_data", u_p0.data_out, 32'hDEAD_BEEF);
    lit("p0_comb_credit", 32'(u_p0.credit_out), 1);
    tick(); idle();
    repeat (4) tick();

    // Randomized traffic, mostly well-formed wormhole packets
    s_open = 0; r_dest = 6'h0;
    for (int i = 0; i < 2500; i++) begin
      idle();
      rst       = ($urandom_range(0, 99) == 0);
      err_clear = ($urandom_range(0, 19) == 0);
      credit_in = ($urandom_range(0, 99) < 45);
      send_in   = ($urandom_range(0, 99) < 50);
      data_in   = $urandom();
      if (send_in) begin
        is_tail_in = ($urandom_range(0, 3) == 0);
        if (!s_open) r_dest = 6'($urandom());
        dest_in = ($urandom_range(0, 19) == 0) ? 6'($urandom()) : r_dest;
        s_open  = !is_tail_in;
      end else begin
        dest_in    = 6'($urandom());
        is_tail_in = ($urandom_range(0, 1) == 1);
      end
      if (rst) s_open = 0;
      tick();
    end
    idle();
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_pipeline_link.md
Name: noc_pipeline_link

Overview:
- Credit-based, wormhole-flit retiming link placed between one router output port and the neighbouring router input port, or between the local-port shims and the router.
- Inserts NUM_PIPELINE register stages on the forward flit path (data/dest/is_tail/send). Inserts the same number of stages on the reverse credit path.
- Includes an upstream-side protocol monitor with:
  - a credit counter,
  - wormhole packet/destination checks,
  - flit and packet counters for bring-up and debug.

Parameters:
- NUM_PIPELINE, 1, number of register stages in each direction; 0 means combinational pass-through.
- FLIT_WIDTH, 32, flit payload width.
- DEST_WIDTH, 6, destination field width (TDEST_WIDTH + TID_WIDTH).
- FLIT_BUFFER_DEPTH, 4, downstream input buffer depth; initial credit count.
- CNT_WIDTH, 32, width of the flit and packet statistic counters.

Ports:
- clk  in  1  link clock (NoC clock domain)
- rst  in  1  synchronous reset, active-high
- data_in  in  FLIT_WIDTH  flit payload from upstream sender
- dest_in  in  DEST_WIDTH  flit destination
- is_tail_in  in  1  last flit of packet
- send_in  in  1  flit valid, one flit per cycle
- credit_out  out  1  credit returned to upstream sender
- data_out  out  FLIT_WIDTH  delayed payload to downstream
- dest_out  out  DEST_WIDTH  delayed destination
- is_tail_out  out  1  delayed tail flag
- send_out  out  1  delayed valid
- credit_in  in  1  credit from downstream buffer
- credits_avail  out  $clog2(FLIT_BUFFER_DEPTH+1)  credits currently held by the upstream sender
- err_clear  in  1  clears the sticky error flags
- err_overrun  out  1  sticky: send_in observed with no credit
- err_credit  out  1  sticky: credit return exceeded FLIT_BUFFER_DEPTH
- err_dest  out  1  sticky: dest changed inside a packet
- flit_count  out  CNT_WIDTH  flits accepted at send_in, wraps
- pkt_count  out  CNT_WIDTH  tails accepted at send_in, wraps

Behaviour:
- Clocking and reset: single clock; all flops reset synchronously when rst=1.
- Forward path:
  - Latency is exactly NUM_PIPELINE cycles from send_in to send_out.
  - Stage k send bit resets to 0.
  - Stage k data/dest/is_tail registers load only when the stage k-1 send bit is 1; otherwise they hold. These registers have no reset, and send gates them.
  - Downstream must only use data_out, dest_out and is_tail_out when send_out=1.
- Reverse path:
  - Latency is exactly NUM_PIPELINE cycles from credit_in to credit_out.
  - Credit stages reset to 0.
  - Every credit pulse is preserved: no merging and no loss.
- NUM_PIPELINE=0: all outputs are wired straight through. The monitor stays active.
- Reset values:
  - send_out=0, is_tail_out=0, credit_out=0.
  - credits_avail=FLIT_BUFFER_DEPTH.
  - All error flags 0; flit_count=0, pkt_count=0.
  - The packet-open flag is cleared.
  - Reset mid-packet discards all in-flight flits and credits with no error.
- Credit counter (upstream view):
  - Updates as next = cur - send_in + credit_out.
  - send_in and credit_out in the same cycle give no change and no error.
  - send_in=1, credit_out=0, cur=0: set err_overrun; counter stays 0 (saturate).
  - credit_out=1, send_in=0, cur=FLIT_BUFFER_DEPTH: set err_credit; counter stays at FLIT_BUFFER_DEPTH.
- Packet monitor:
  - Head flit is send_in while packet-open=0. It captures dest_in and sets packet-open, unless is_tail_in=1 (single-flit packet).
  - Body or tail flit with dest_in differing from the captured dest sets err_dest.
  - A tail flit clears packet-open.
- Statistic counters:
  - flit_count increments on every send_in.
  - pkt_count increments on send_in & is_tail_in.
  - Both wrap modulo 2^CNT_WIDTH.
  - Both count regardless of error conditions.
- Sticky errors:
  - A flag stays set until err_clear=1 or rst=1.
  - If err_clear and a new error event occur in the same cycle, set wins (the flag reads 1 next cycle).
- The forward and credit paths are never altered by monitor state; the monitor is observe-only.

Decomposition:
- Shared package noc_link_pkg holds:
  - typedef flit_t: packed {data, dest, is_tail}.
  - Function credit_cnt_width(depth) = $clog2(depth+1).
- Sub-module noc_link_monitor contains the credit counter, packet-open/dest check, sticky flags and statistic counters.
- The top level contains two generate-loop shift pipelines (forward flit, reverse credit) and instantiates the monitor on the send_in/credit_out side.

Test Plan:
- NUM_PIPELINE=2; send 3-flit packet dest=6'h15 on cycles 10–12 -> send_out high cycles 12–14 with identical data/dest, is_tail_out on cycle 14; pkt_count=1, flit_count=3.
- Depth 4; send 4 flits with no credits -> credits_avail 4→0, no error. Fifth send -> err_overrun=1, credits_avail stays 0.
- credit_in pulses on cycles 20 and 21 with NUM_PIPELINE=3 -> credit_out pulses on cycles 23 and 24 exactly. Simultaneous send_in and credit_out at count 2 -> count stays 2.
- Body flit with dest 6'h03 after head 6'h05 -> err_dest=1. err_clear one cycle -> err_dest=0. err_clear coincident with a new mismatch -> err_dest stays 1.
- Extra credit_out at count=4 -> err_credit=1, count stays 4.
- Assert rst mid-packet with flits in the pipe -> next cycle send_out=0, credit_out=0, credits_avail=4, counters 0. A new head is accepted without err_dest.
- NUM_PIPELINE=0 -> outputs combinationally equal to inputs in the same cycle; monitor counts are identical to the piped case.
